control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin or resume execution; level-sampled.
REQ-004 SHALL have port ir, input, 16 bits: instruction register contents; opcode = ir[15:8].
REQ-005 SHALL have port z, input, 1 bit: ALU zero flag for JMPZ.
REQ-006 SHALL have port control_register, output, 6 bits: bus source one-hot; r=1, ar=2, dr=4, ac=8, pc=16, ir=32.
REQ-007 SHALL have port control_memory, output, 2 bits: bus source; 01 = dram, 10 = iram.
REQ-008 SHALL have port load, output, 6 bits: register load enables, same bit order as control_register.
REQ-009 SHALL have port pc_inc, output, 1 bit: PC increment.
REQ-010 SHALL have port alu_op, output, 3 bits: 000 = pass, 001 = add.
REQ-011 SHALL have port dram_write, output, 1 bit: DRAM write of dr at address ar.
REQ-012 SHALL have port done, output, 1 bit: high while halted.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, F1, F2, DEC, E1, E2, HALT; outputs SHALL decode only from state, registered ir and z.
REQ-014 SHALL drive at most one set bit across {control_memory, control_register} in every cycle; all-zero means bus idle.
REQ-015 IDLE: all outputs 0; start=1 -> F1, else stay.
REQ-016 F1: bus=pc, load[ar]=1; -> F2.
REQ-017 F2: control_memory=10, load[ir]=1, pc_inc=1; -> DEC.
REQ-018 DEC: all outputs 0; opcode routes: 0x00 NOP -> F1; 0xFF END -> HALT; 0x01-0x07 -> E1; any other opcode -> F1, executed as NOP.
REQ-019 LDAR 0x01: E1 bus=pc, load[ar]; E2 bus=iram, load[ar], pc_inc; -> F1.
REQ-020 LDAC 0x02: E1 bus=dram, load[ac]; -> F1.
REQ-021 STAC 0x03: E1 bus=ac, load[dr]; E2 dram_write=1, bus idle; -> F1.
REQ-022 MVR 0x04: E1 bus=ac, load[r]; -> F1.
REQ-023 ADD 0x05: E1 bus=r, alu_op=001, load[ac]; -> F1.
REQ-024 JUMP 0x06: E1 bus=pc, load[ar]; E2 bus=iram, load[pc]; -> F1.
REQ-025 JMPZ 0x07: z sampled in E1; z=1 behaves as JUMP; z=0 E1 pc_inc=1 only, -> F1.
REQ-026 Latency SHALL be: NOP/unknown 3 cycles; LDAC/MVR/ADD/JMPZ-not-taken 4; LDAR/STAC/JUMP/JMPZ-taken 5.
REQ-027 HALT: done=1, other outputs 0; start=1 -> F1; otherwise stay.
REQ-028 start SHALL be ignored in every state except IDLE and HALT.
REQ-029 pc_inc and load[pc] SHALL never be asserted in the same cycle.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE in any state, including mid-instruction; all outputs SHALL be 0 in the following cycle.
REQ-031 rst SHALL take priority over start.

Structure
REQ-032 A shared package SHALL hold the state enum, opcode constants, bus-select one-hot constants, and alu_op codes.
REQ-033 The state-to-output decode SHALL be one combinational sub-module, control_decode; the FSM register and next-state logic SHALL stay in control_unit.

Verification
REQ-034 Reset, then start=1 with ir=0x0000: sequence F1, F2, DEC, F1 repeats; bus values 16, 128, 0; no load[pc].
REQ-035 ir=0x0500 (ADD): E1 shows control_register=1, alu_op=001, load=001000; back in F1 on the 5th cycle after start.
REQ-036 ir=0x0700 with z=0: pc_inc=1 in E1, exactly 4 cycles. With z=1: E2 has control_memory=10 and load[pc]=1.
REQ-037 ir=0xFF00: HALT with done=1 held for 10 cycles; start=1 -> F1 and done=0.
REQ-038 rst=1 during STAC E1: next cycle IDLE, dram_write never asserted, all outputs 0.
REQ-039 Every cycle of a random opcode stream: popcount({control_memory, control_register}) <= 1, and no pc_inc together with load[pc].

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared definitions for the accumulator-machine control unit: FSM states,
// opcodes, bus-source encodings and ALU operation codes.
package control_unit_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_F1,
      S_F2,
      S_DEC,
      S_E1,
      S_E2,
      S_HALT
   } state_t;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDAR = 8'h01;
   localparam logic [7:0] OP_LDAC = 8'h02;
   localparam logic [7:0] OP_STAC = 8'h03;
   localparam logic [7:0] OP_MVR  = 8'h04;
   localparam logic [7:0] OP_ADD  = 8'h05;
   localparam logic [7:0] OP_JUMP = 8'h06;
   localparam logic [7:0] OP_JMPZ = 8'h07;
   localparam logic [7:0] OP_END  = 8'hFF;

   // Register one-hots; also the bit order of the load enables.
   localparam logic [5:0] REG_NONE = 6'b000000;
   localparam logic [5:0] REG_R    = 6'b000001;
   localparam logic [5:0] REG_AR   = 6'b000010;
   localparam logic [5:0] REG_DR   = 6'b000100;
   localparam logic [5:0] REG_AC   = 6'b001000;
   localparam logic [5:0] REG_PC   = 6'b010000;
   localparam logic [5:0] REG_IR   = 6'b100000;

   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_DRAM = 2'b01;
   localparam logic [1:0] MEM_IRAM = 2'b10;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;

   function automatic logic is_exec(input logic [7:0] op);
      return (op >= OP_LDAR) && (op <= OP_JMPZ);
   endfunction

   // Instructions that need a second execute cycle; JMPZ only when taken.
   function automatic logic has_e2(input logic [7:0] op, input logic z);
      return (op == OP_LDAR) || (op == OP_STAC) || (op == OP_JUMP) ||
             ((op == OP_JMPZ) && z);
   endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: control signals as a pure function of the FSM state,
// the current opcode and the ALU zero flag.
module control_decode
   import control_unit_pkg::*;
(
   input  state_t     state,
   input  logic [7:0] opcode,
   input  logic       z,
   output logic [5:0] control_register,
   output logic [1:0] control_memory,
   output logic [5:0] load,
   output logic       pc_inc,
   output logic [2:0] alu_op,
   output logic       dram_write,
   output logic       done
);

   always_comb begin
      control_register = REG_NONE;
      control_memory   = MEM_NONE;
      load             = REG_NONE;
      pc_inc           = 1'b0;
      alu_op           = ALU_PASS;
      dram_write       = 1'b0;
      done             = 1'b0;
      case (state)
         S_F1: begin
            control_register = REG_PC;
            load             = REG_AR;
         end
         S_F2: begin
            control_memory = MEM_IRAM;
            load           = REG_IR;
            pc_inc         = 1'b1;
         end
         S_E1: begin
            case (opcode)
               OP_LDAR, OP_JUMP: begin
                  control_register = REG_PC;
                  load             = REG_AR;
               end
               OP_LDAC: begin
                  control_memory = MEM_DRAM;
                  load           = REG_AC;
               end
               OP_STAC: begin
                  control_register = REG_AC;
                  load             = REG_DR;
               end
               OP_MVR: begin
                  control_register = REG_AC;
                  load             = REG_R;
               end
               OP_ADD: begin
                  control_register = REG_R;
                  alu_op           = ALU_ADD;
                  load             = REG_AC;
               end
               OP_JMPZ: begin
                  // Taken: fetch the target address like JUMP; else skip the operand byte.
                  if (z) begin
                     control_register = REG_PC;
                     load             = REG_AR;
                  end else begin
                     pc_inc = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         S_E2: begin
            case (opcode)
               OP_LDAR: begin
                  control_memory = MEM_IRAM;
                  load           = REG_AR;
                  pc_inc         = 1'b1;
               end
               OP_STAC: dram_write = 1'b1;
               OP_JUMP, OP_JMPZ: begin
                  control_memory = MEM_IRAM;
                  load           = REG_PC;
               end
               default: ;
            endcase
         end
         S_HALT: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Control unit FSM: fetch/decode/execute sequencing for the accumulator
// machine. Outputs come from control_decode, driven by the state register.
module control_unit
   import control_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] ir,
   input  logic        z,
   output logic [5:0]  control_register,
   output logic [1:0]  control_memory,
   output logic [5:0]  load,
   output logic        pc_inc,
   output logic [2:0]  alu_op,
   output logic        dram_write,
   output logic        done
);

   state_t     state;
   logic [7:0] opcode;
   logic       unused_operand;

   assign opcode         = ir[15:8];
   assign unused_operand = ^ir[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (start) state <= S_F1;
            S_F1:    state <= S_F2;
            S_F2:    state <= S_DEC;
            S_DEC: begin
               if (opcode == OP_END)     state <= S_HALT;
               else if (is_exec(opcode)) state <= S_E1;
               else                      state <= S_F1;
            end
            S_E1:    state <= has_e2(opcode, z) ? S_E2 : S_F1;
            S_E2:    state <= S_F1;
            S_HALT:  if (start) state <= S_F1;
            default: state <= S_IDLE;
         endcase
      end
   end

   control_decode u_decode (
      .state            (state),
      .opcode           (opcode),
      .z                (z),
      .control_register (control_register),
      .control_memory   (control_memory),
      .load             (load),
      .pc_inc           (pc_inc),
      .alu_op           (alu_op),
      .dram_write       (dram_write),
      .done             (done)
   );

endmodule
